// File: rtl/ball_motion_ctrl_if.sv
// Collision-checker handshake between the ball sequencer and the external
// brick/paddle checker. The sequencer is the master: it raises chk_req with a
// candidate position and holds it until the checker answers with chk_valid.
interface ball_motion_ctrl_if;
    logic       chk_req;
    logic [9:0] chk_x;
    logic [9:0] chk_y;
    logic       chk_valid;
    logic [1:0] chk_hit;

    modport master (output chk_req, chk_x, chk_y, input chk_valid, chk_hit);
    modport slave  (input chk_req, chk_x, chk_y, output chk_valid, chk_hit);
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: on each frame tick it forms the candidate
// position, handles screen edges locally, asks the collision checker about
// the rest, then commits the move or reflects the direction. Also keeps the
// lives count and the game-over flag.
module ball_motion_ctrl #(
    parameter int X_MAX       = 480,
    parameter int Y_MAX       = 640,
    parameter int START_X     = 240,
    parameter int START_Y     = 320,
    parameter int LIVES       = 3,
    parameter int CHK_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      tick,
    input  logic                      launch,
    input  logic [6:0]                xstep,
    input  logic [6:0]                ystep,
    ball_motion_ctrl_if.master        chk,
    output logic [9:0]                ball_x,
    output logic [9:0]                ball_y,
    output logic [1:0]                dir,
    output logic                      busy,
    output logic                      ball_lost,
    output logic [1:0]                lives,
    output logic                      game_over
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EDGE, S_REQ} state_t;

    localparam int TW = $clog2(CHK_TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;

    // 11-bit views so that sums and edge comparisons never wrap
    logic [10:0] x_w, y_w, xs_w, ys_w;
    logic [9:0]  nx, ny;
    logic        lost, x_edge, top_edge, req_timeout, req_done;

    // Candidate position and edge classification for the current frame
    always_comb begin
        x_w         = {1'b0, ball_x};
        y_w         = {1'b0, ball_y};
        xs_w        = {4'b0, xstep};
        ys_w        = {4'b0, ystep};
        // Only used when no edge is hit, so the 10-bit results are in range
        nx          = dir[0] ? ball_x - 10'(xstep) : ball_x + 10'(xstep);
        ny          = dir[1] ? ball_y - 10'(ystep) : ball_y + 10'(ystep);
        lost        = !dir[1] && (y_w + ys_w >= 11'(Y_MAX));
        x_edge      = dir[0] ? (x_w <= xs_w) : (x_w + xs_w >= 11'(X_MAX));
        top_edge    = dir[1] && (y_w <= ys_w);
        req_timeout = (timer == TW'(CHK_TIMEOUT - 1));
        req_done    = chk.chk_valid || req_timeout;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; ticks and launches outside their state are dropped
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch && !game_over) state_nxt = S_WAIT;
            S_WAIT:  if (tick) state_nxt = S_EDGE;
            S_EDGE: begin
                if (lost)                     state_nxt = S_IDLE;
                else if (x_edge || top_edge)  state_nxt = S_WAIT;
                else                          state_nxt = S_REQ;
            end
            S_REQ:   if (req_done) state_nxt = S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Decoded from state so a reset mid-handshake drops the request at once
    assign chk.chk_req = (state == S_REQ);
    assign busy        = (state == S_EDGE) || (state == S_REQ);

    // Position, direction, candidate, timeout and lives bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ball_x    <= 10'(START_X);
            ball_y    <= 10'(START_Y);
            dir       <= 2'b00;
            chk.chk_x <= '0;
            chk.chk_y <= '0;
            timer     <= '0;
            ball_lost <= 1'b0;
            lives     <= 2'(LIVES);
            game_over <= 1'b0;
        end else begin
            ball_lost <= 1'b0;
            case (state)
                S_EDGE: begin
                    timer <= '0;
                    if (lost) begin
                        ball_lost <= 1'b1;
                        lives     <= lives - 2'd1;
                        ball_x    <= 10'(START_X);
                        ball_y    <= 10'(START_Y);
                        dir       <= 2'b00;
                        if (lives == 2'd1) game_over <= 1'b1;
                    end else if (x_edge || top_edge) begin
                        dir <= dir ^ {top_edge, x_edge};
                    end else begin
                        chk.chk_x <= nx;
                        chk.chk_y <= ny;
                    end
                end
                S_REQ: begin
                    timer <= timer + 1'b1;
                    if (chk.chk_valid && chk.chk_hit[1]) begin
                        dir[chk.chk_hit[0]] <= ~dir[chk.chk_hit[0]];
                    end else if (req_done) begin
                        ball_x <= chk.chk_x;
                        ball_y <= chk.chk_y;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: directed scenarios plus random
// frames, all predicted by a frame-level reference model of the game rules.
module tb_ball_motion_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic       launch = 1'b0;
    logic [6:0] xstep = '0;
    logic [6:0] ystep = '0;
    logic [9:0] ball_x, ball_y;
    logic [1:0] dir, lives;
    logic       busy, ball_lost, game_over;

    ball_motion_ctrl_if chk_if ();

    ball_motion_ctrl dut (
        .clk(clk), .resetn(resetn), .tick(tick), .launch(launch),
        .xstep(xstep), .ystep(ystep), .chk(chk_if.master),
        .ball_x(ball_x), .ball_y(ball_y), .dir(dir), .busy(busy),
        .ball_lost(ball_lost), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int         m_x, m_y, m_lives;
    logic [1:0] m_dir;
    bit         m_go, m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_x = 240; m_y = 320; m_dir = 2'b00; m_lives = 3; m_go = 0; m_idle = 1;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, 32'(ball_x), 32'(m_x));
        check({tag, "_y"}, 32'(ball_y), 32'(m_y));
        check({tag, "_dir"}, 32'(dir), 32'(m_dir));
    endtask

    task automatic do_launch();
        launch = 1'b1;
        @(posedge clk); #1;
        launch = 1'b0;
        if (!m_go) m_idle = 0;
        check("launch_busy", 32'(busy), 0);
    endtask

    // One frame starting from WAIT. d = checker reply cycle (1..15), 0 = withheld.
    task automatic frame(input int xs, input int ys, input int d, input logic [1:0] hit,
                         input bit drop_tick);
        int nx, ny, edges, exp_edges;
        bit xe, te;
        xstep = 7'(xs); ystep = 7'(ys);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        if (!m_dir[1] && (m_y + ys >= 640)) begin
            m_lives--; m_x = 240; m_y = 320; m_dir = 2'b00; m_idle = 1;
            if (m_lives == 0) m_go = 1;
            check("lost_pulse", 32'(ball_lost), 1);
            check("lost_lives", 32'(lives), 32'(m_lives));
            check("lost_game_over", 32'(game_over), 32'(m_go));
            check_pos("lost");
            @(posedge clk); #1;
            check("lost_pulse_end", 32'(ball_lost), 0);
            check("lost_idle_busy", 32'(busy), 0);
            return;
        end
        xe = m_dir[0] ? (m_x <= xs) : (m_x + xs >= 480);
        te = m_dir[1] && (m_y <= ys);
        if (xe || te) begin
            m_dir = m_dir ^ {te, xe};
            check("edge_no_req", 32'(chk_if.chk_req), 0);
            check("edge_busy", 32'(busy), 0);
            check_pos("edge");
            return;
        end
        nx = m_dir[0] ? m_x - xs : m_x + xs;
        ny = m_dir[1] ? m_y - ys : m_y + ys;
        check("req_high", 32'(chk_if.chk_req), 1);
        check("req_x", 32'(chk_if.chk_x), 32'(nx));
        check("req_y", 32'(chk_if.chk_y), 32'(ny));
        edges = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == d) begin chk_if.chk_valid = 1'b1; chk_if.chk_hit = hit; end
            if (drop_tick && n == 1) tick = 1'b1;
            @(posedge clk); #1;
            chk_if.chk_valid = 1'b0; chk_if.chk_hit = 2'b00; tick = 1'b0;
            edges = n;
            if (!chk_if.chk_req) break;
        end
        exp_edges = (d >= 1 && d <= 15) ? d : 15;
        if (d >= 1 && d <= 15 && hit[1]) m_dir[hit[0]] = ~m_dir[hit[0]];
        else begin m_x = nx; m_y = ny; end
        check("req_cycles", 32'(edges), 32'(exp_edges));
        check("commit_busy", 32'(busy), 0);
        check_pos("commit");
        if (drop_tick) begin
            repeat (3) begin @(posedge clk); #1; end
            check("dropped_tick_req", 32'(chk_if.chk_req), 0);
            check("dropped_tick_busy", 32'(busy), 0);
            check_pos("dropped_tick");
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_if.chk_valid = 1'b0;
        chk_if.chk_hit   = 2'b00;
        model_reset();
        apply_reset();

        // Reset values
        check_pos("reset");
        check("reset_lives", 32'(lives), 3);
        check("reset_game_over", 32'(game_over), 0);
        check("reset_req", 32'(chk_if.chk_req), 0);
        check("reset_chk_x", 32'(chk_if.chk_x), 0);
        check("reset_chk_y", 32'(chk_if.chk_y), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_lost", 32'(ball_lost), 0);

        // Tick while IDLE is ignored
        tick = 1'b1; @(posedge clk); #1; tick = 1'b0;
        @(posedge clk); #1;
        check("idle_tick_busy", 32'(busy), 0);

        // Serve and a plain committed move
        do_launch();
        frame(10, 7, 2, 2'b00, 0);
        check("t1_x", 32'(ball_x), 250);
        check("t1_y", 32'(ball_y), 327);
        check("t1_req_low", 32'(chk_if.chk_req), 0);

        // Walk right to x=475, then the right edge reflects
        for (int i = 0; i < 60 && m_x < 475; i++) frame(5, 0, 1, 2'b00, 0);
        check("t2_pre_x", 32'(ball_x), 475);
        frame(5, 0, 1, 2'b00, 0);
        check("t2_dir", 32'(dir), 1);
        check("t2_x", 32'(ball_x), 475);

        // Checker reports a Y-axis hit
        frame(5, 5, 3, 2'b11, 0);
        check("t5_dir", 32'(dir), 3);
        check("t5_x", 32'(ball_x), 475);

        // Up-left to (15,7), then a corner reflect
        repeat (21) frame(23, 16, 1, 2'b00, 0);
        check("t3_dir", 32'(dir), 0);
        check("t3_x", 32'(ball_x), 15);
        check("t3_y", 32'(ball_y), 7);

        // Drop through the bottom edge
        for (int i = 0; i < 20 && !m_idle; i++) frame(0, 127, 1, 2'b00, 0);
        check("t4_lives", 32'(lives), 2);
        do_launch();

        // Checker silent: commit after the timeout; then a tick during REQ
        frame(3, 3, 0, 2'b00, 0);
        frame(2, 2, 4, 2'b00, 1);

        // Reset in the middle of a handshake
        xstep = 7'd0; ystep = 7'd0; tick = 1'b1;
        @(posedge clk); #1; tick = 1'b0;
        @(posedge clk); #1;
        check("midreq_req", 32'(chk_if.chk_req), 1);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check("midreq_req_drop", 32'(chk_if.chk_req), 0);
        check_pos("midreq");
        check("midreq_lives", 32'(lives), 3);
        check("midreq_busy", 32'(busy), 0);
        check("midreq_chk_x", 32'(chk_if.chk_x), 0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        do_launch();

        // Random frames against the model
        for (int i = 0; i < 40 && !m_go; i++) begin
            frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 0);
            if (m_idle && !m_go) do_launch();
        end

        // Lose every life, then launch must be ignored
        apply_reset();
        do_launch();
        for (int i = 0; i < 40 && !m_go; i++) begin
            frame(0, 127, 1, 2'b00, 0);
            if (m_idle && !m_go) do_launch();
        end
        check("go_lives", 32'(lives), 0);
        check("go_flag", 32'(game_over), 1);
        launch = 1'b1; @(posedge clk); #1; launch = 1'b0;
        tick = 1'b1;   @(posedge clk); #1; tick = 1'b0;
        @(posedge clk); #1;
        check("go_launch_ignored_busy", 32'(busy), 0);
        check("go_launch_ignored_req", 32'(chk_if.chk_req), 0);
        check("go_still_set", 32'(game_over), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
